// File: rtl/mp_ram.sv
// Multi-port single-array RAM: round-robin arbitrated OBI-style requestors, configurable read
// latency and an error response for out-of-range addresses.
module mp_ram #(
    parameter int unsigned           NUM_PORTS  = 2,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_WORDS  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           RD_LATENCY = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_PORTS-1:0]             req_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [NUM_PORTS-1:0]             err_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);
    localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned IdxW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef struct packed {
        logic                  valid;
        logic [PortW-1:0]      port;
        logic                  err;
        logic                  we;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    logic [PortW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]  gnt;
    logic                  gnt_any;
    logic [PortW-1:0]      gnt_idx;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [NumBytes-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IdxW-1:0]       mem_idx;
    logic                  oor;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    stage_t                pipe_q [RD_LATENCY];
    stage_t                stage_in;
    stage_t                last;

    // Two passes: ports at or above the pointer first, then wrap to the lowest requester.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (rst_ni) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!gnt_any && req_i[p] && (p >= 32'(rr_ptr_q))) begin
                    gnt_any = 1'b1;
                    gnt_idx = PortW'(p);
                    gnt[p]  = 1'b1;
                end
            end
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!gnt_any && req_i[p]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PortW'(p);
                    gnt[p]  = 1'b1;
                end
            end
        end
    end

    assign gnt_o = gnt;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            if (32'(gnt_idx) == NUM_PORTS - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we    = we_i[p];
                sel_be    = be_i[p*NumBytes +: NumBytes];
                sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Byte-offset bits are dropped by the shift, so misalignment is never an error.
    assign offset   = sel_addr - BASE_ADDR;
    assign word_idx = offset >> OffBits;
    assign oor      = (sel_addr < BASE_ADDR) || (word_idx >= ADDR_WIDTH'(NUM_WORDS));
    assign mem_idx  = word_idx[IdxW-1:0];
    assign rd_data  = oor ? '0 : mem_q[mem_idx];

    always_ff @(posedge clk_i) begin
        if (gnt_any && sel_we && !oor) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (sel_be[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        stage_in       = '0;
        stage_in.valid = gnt_any;
        stage_in.port  = gnt_idx;
        stage_in.err   = oor;
        stage_in.we    = sel_we;
        stage_in.data  = rd_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_in;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[RD_LATENCY-1];

    // Writes and errors return zero data; only in-range reads carry the array word.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (last.valid) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (last.port == PortW'(p)) begin
                    rvalid_o[p] = 1'b1;
                    err_o[p]    = last.err;
                    rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = (last.err || last.we) ? '0 : last.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_ram.sv
// Randomised bench for mp_ram: latency-1 and latency-3 instances share stimulus and are checked
// every cycle against a transaction-level model of arbitration, array contents and responses.
module tb_mp_ram;

    localparam int NP   = 3;
    localparam int NW   = 256;
    localparam logic [31:0] TB_BASE = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    p_req = '0;
    logic [NP-1:0]    p_we  = '0;
    logic [31:0]      p_addr [NP];
    logic [3:0]       p_be   [NP];
    logic [31:0]      p_wd   [NP];

    logic [NP-1:0]    req, we;
    logic [NP*32-1:0] addr, wdata;
    logic [NP*4-1:0]  be;

    always_comb begin
        req = p_req;
        we  = p_we;
        addr = '0;
        wdata = '0;
        be = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p*32 +: 32]  = p_addr[p];
            wdata[p*32 +: 32] = p_wd[p];
            be[p*4 +: 4]      = p_be[p];
        end
    end

    logic [NP-1:0]    gnt1, rv1, err1, gnt3, rv3, err3;
    logic [NP*32-1:0] rd1, rd3;

    mp_ram #(.NUM_PORTS(NP), .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(NW),
             .BASE_ADDR(TB_BASE), .RD_LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .err_o(err1), .rdata_o(rd1)
    );

    mp_ram #(.NUM_PORTS(NP), .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(NW),
             .BASE_ADDR(TB_BASE), .RD_LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rv3), .err_o(err3), .rdata_o(rd3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] data;
    } resp_t;
    typedef struct {
        int cyc;
        int port;
    } ev_t;

    logic [31:0]   mmem [NW];
    int unsigned   mptr = 0;
    logic [NP-1:0] mgnt = '0;
    int            cyc = 0;
    resp_t         q1[$], q3[$];

    bit            log_en = 1'b0;
    ev_t           glog[$], r1log[$], r3log[$];
    logic [31:0]   last1_data = '0;
    logic          last1_err = 1'b0;
    int            rv3_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NP-1:0] arb(input logic [NP-1:0] r, input int unsigned ptr);
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (int'(ptr) + i) % NP;
            if (r[p]) return NP'(1) << p;
        end
        return '0;
    endfunction

    function automatic int oh2i(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Compare process: all DUT outputs are checked on every falling edge.
    initial begin
        logic [NP-1:0]    eg, ev1, ee1, ev3, ee3;
        logic [NP*32-1:0] ed1, ed3;
        resp_t            r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q1.delete();
                q3.delete();
                mptr = 0;
                eg = '0;
            end else begin
                eg = arb(req, mptr);
            end
            mgnt = eg;
            chk("gnt_l1", 96'(gnt1), 96'(eg));
            chk("gnt_l3", 96'(gnt3), 96'(eg));

            ev1 = '0; ee1 = '0; ed1 = '0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                ev1[r.port] = 1'b1;
                ee1[r.port] = r.err;
                ed1[r.port*32 +: 32] = r.data;
            end
            ev3 = '0; ee3 = '0; ed3 = '0;
            if (q3.size() > 0 && q3[0].due == cyc) begin
                r = q3.pop_front();
                ev3[r.port] = 1'b1;
                ee3[r.port] = r.err;
                ed3[r.port*32 +: 32] = r.data;
            end
            chk("rvalid_l1", 96'(rv1), 96'(ev1));
            chk("err_l1", 96'(err1), 96'(ee1));
            chk("rdata_l1", 96'(rd1), 96'(ed1));
            chk("rvalid_l3", 96'(rv3), 96'(ev3));
            chk("err_l3", 96'(err3), 96'(ee3));
            chk("rdata_l3", 96'(rd3), 96'(ed3));

            if (rv1 != '0) begin
                last1_data = rd1[oh2i(rv1)*32 +: 32];
                last1_err  = err1[oh2i(rv1)];
                if (log_en) r1log.push_back('{cyc, oh2i(rv1)});
            end
            if (rv3 != '0) begin
                rv3_count++;
                if (log_en) r3log.push_back('{cyc, oh2i(rv3)});
            end
            if (log_en && gnt1 != '0) glog.push_back('{cyc, oh2i(gnt1)});

            if (eg != '0) begin
                int          k;
                logic [31:0] a, idx, d;
                logic        o;
                k   = oh2i(eg);
                a   = p_addr[k];
                idx = (a - TB_BASE) / 4;
                o   = (a < TB_BASE) || (idx >= NW);
                d   = 32'h0;
                if (!o && !p_we[k]) d = mmem[idx];
                if (!o && p_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[k][b]) mmem[idx][b*8 +: 8] = p_wd[k][b*8 +: 8];
                end
                q1.push_back('{cyc + 1, k, o, d});
                q3.push_back('{cyc + 3, k, o, d});
                mptr = (k + 1) % NP;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request on port p and hold it until the model grants it.
    task automatic single(input int p, input bit w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d);
        p_req[p] = 1'b1;
        p_we[p] = w;
        p_addr[p] = a;
        p_be[p] = b;
        p_wd[p] = d;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (mgnt[p]) begin
                #1;
                p_req[p] = 1'b0;
                return;
            end
        end
        chk("grant_timeout", 96'(0), 96'(1));
        p_req[p] = 1'b0;
    endtask

    task automatic new_req(input int p);
        p_req[p]  = 1'b1;
        p_we[p]   = 1'($urandom_range(0, 1));
        p_addr[p] = ($urandom_range(0, 99) < 8) ? 32'h400 + $urandom_range(0, 1023)
                                                : 32'($urandom_range(0, 1023));
        p_be[p]   = 4'($urandom_range(0, 15));
        p_wd[p]   = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   init0;
        logic [NP-1:0] g;
        int            snap, rst_hold, n;

        for (int p = 0; p < NP; p++) begin
            p_addr[p] = 32'h0;
            p_be[p] = 4'hF;
            p_wd[p] = 32'h0;
        end
        init0 = 32'h0;

        chk("arb_pin_wrap", 96'(arb(3'b011, 2)), 96'(3'b001));
        chk("arb_pin_ptr", 96'(arb(3'b101, 1)), 96'(3'b100));

        // Reset with every port requesting a write of zero to word 0
        p_req = '1;
        p_we = '1;
        repeat (4) @(negedge clk);
        chk("rst_gnt", 96'(gnt1), 96'(0));
        chk("rst_rvalid", 96'({rv1, rv3}), 96'(0));
        chk("rst_err", 96'({err1, err3}), 96'(0));
        chk("rst_rdata", 96'(rd1 | rd3), 96'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_gnt_l1", 96'(gnt1), 96'(3'b001));
        chk("first_gnt_l3", 96'(gnt3), 96'(3'b001));
        @(posedge clk);
        #1 p_req = '0;

        for (int w = 0; w < NW; w++) begin
            logic [31:0] d;
            d = $urandom;
            if (w == 0) init0 = d;
            single(0, 1'b1, 32'(w * 4), 4'hF, d);
        end

        single(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        single(0, 1'b0, 32'h10, 4'hF, 32'h0);
        wait_cycles(3);
        chk("wr_rd_data", 96'(last1_data), 96'(32'hDEADBEEF));
        chk("wr_rd_err", 96'(last1_err), 96'(0));

        single(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
        single(0, 1'b0, 32'h10, 4'hF, 32'h0);
        wait_cycles(3);
        chk("be_data", 96'(last1_data), 96'(32'hDE22BE44));
        chk("be_model", 96'(mmem[4]), 96'(32'hDE22BE44));

        single(0, 1'b1, 32'h400, 4'hF, 32'h12345678);
        wait_cycles(3);
        chk("oor_err", 96'(last1_err), 96'(1));
        chk("oor_rdata", 96'(last1_data), 96'(0));
        single(0, 1'b0, 32'h0, 4'hF, 32'h0);
        wait_cycles(3);
        chk("oor_word0", 96'(last1_data), 96'(init0));

        // Contention: park the pointer at 0, then ports 0 and 1 request for 6 cycles
        single(2, 1'b0, 32'h20, 4'hF, 32'h0);
        wait_cycles(4);
        p_we[0] = 1'b0; p_addr[0] = 32'h30;
        p_we[1] = 1'b0; p_addr[1] = 32'h34;
        p_req = 3'b011;
        log_en = 1'b1;
        wait_cycles(6);
        p_req = '0;
        wait_cycles(5);
        log_en = 1'b0;
        chk("cont_ngnt", 96'(glog.size()), 96'(6));
        chk("cont_nrsp_l1", 96'(r1log.size()), 96'(6));
        chk("cont_nrsp_l3", 96'(r3log.size()), 96'(6));
        n = glog.size();
        if (r1log.size() < n) n = r1log.size();
        if (r3log.size() < n) n = r3log.size();
        for (int i = 0; i < n; i++) begin
            chk("cont_gnt_order", 96'(glog[i].port), 96'(i % 2));
            chk("cont_rsp_l1_port", 96'(r1log[i].port), 96'(i % 2));
            chk("cont_rsp_l1_lat", 96'(r1log[i].cyc - glog[i].cyc), 96'(1));
            chk("cont_rsp_l3_port", 96'(r3log[i].port), 96'(i % 2));
            chk("cont_rsp_l3_lat", 96'(r3log[i].cyc - glog[i].cyc), 96'(3));
        end

        // Reset one cycle after a read grant: the latency-3 response must never appear
        snap = rv3_count;
        single(0, 1'b0, 32'h10, 4'hF, 32'h0);
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(6);
        chk("rst_flight_l3", 96'(rv3_count - snap), 96'(0));
        single(0, 1'b0, 32'h10, 4'hF, 32'h0);
        wait_cycles(3);
        chk("rst_keeps_array", 96'(last1_data), 96'(32'hDE22BE44));

        rst_hold = 0;
        repeat (3000) begin
            @(posedge clk);
            g = mgnt;
            #1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                rst_hold = 2;
            end
            for (int p = 0; p < NP; p++) begin
                if (p_req[p] && g[p]) p_req[p] = 1'b0;
                if (!p_req[p] && $urandom_range(0, 2) != 0) new_req(p);
            end
        end
        p_req = '0;
        rst_n = 1'b1;
        wait_cycles(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
